// File: rtl/code_lock_fsm.sv
// code_lock_fsm: keypad code-lock controller with failed-attempt lockout.
// Ports:
//   clk_i, reset_i (sync, active-high)
//   digit_valid_i / digit_i : one-cycle digit strobe from the keypad encoder
//   code_i                  : stored code, first digit in the MS DIGIT_W bits
//   lock_req_i              : relock request, honoured only in UNLOCKED
//   state_o                 : registered state encoding
//   unlocked_o, error_o, lockout_o : decoded state flags
//   tries_left_o            : MAX_TRIES minus consecutive failures
// Optional macro CODE_LOCK_AUTO_RELOCK_EN adds a timed relock out of UNLOCKED.
module code_lock_fsm #(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int UNLOCK_CYCLES  = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          digit_valid_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code_i,
  input  logic                          lock_req_i,
  output logic [2:0]                    state_o,
  output logic                          unlocked_o,
  output logic                          error_o,
  output logic                          lockout_o,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left_o
);
  localparam int BW = NUM_DIGITS * DIGIT_W;
  localparam int CW = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = $clog2(MAX_TRIES + 1);
`ifdef CODE_LOCK_AUTO_RELOCK_EN
  localparam int TMAX = LOCKOUT_CYCLES > UNLOCK_CYCLES ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
`else
  localparam int TMAX = LOCKOUT_CYCLES;
`endif
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    LOCKED   = 3'b000,
    INPUT    = 3'b001,
    VERIFY   = 3'b010,
    ERROR    = 3'b011,
    UNLOCKED = 3'b100,
    LOCKOUT  = 3'b101
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [BW-1:0] buf_shift;

  // Shifting digits in from the LS end leaves the first digit in the MS
  // position after NUM_DIGITS strobes, matching the layout of code_i.
  assign buf_shift = {buf_q[BW-DIGIT_W-1:0], digit_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    tmr_d   = tmr_q;
    fail_d  = fail_q;
    case (state_q)
      LOCKED: if (digit_valid_i) begin
        buf_d   = buf_shift;
        cnt_d   = CW'(1);
        state_d = INPUT;
      end
      INPUT: if (digit_valid_i) begin
        buf_d   = buf_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NUM_DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = VERIFY;
        end
      end
      VERIFY: if (buf_q == code_i) begin
        fail_d  = '0;
        state_d = UNLOCKED;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
        tmr_d   = TW'(UNLOCK_CYCLES - 1);
`endif
      end else begin
        fail_d  = fail_q + 1'b1;
        state_d = ERROR;
        if (fail_q == FW'(MAX_TRIES - 1)) begin
          tmr_d   = TW'(LOCKOUT_CYCLES - 1);
          state_d = LOCKOUT;
        end
      end
      ERROR: state_d = LOCKED;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
      UNLOCKED: begin
        tmr_d   = tmr_q - 1'b1;
        state_d = (lock_req_i || tmr_q == '0) ? LOCKED : UNLOCKED;
      end
`else
      UNLOCKED: state_d = lock_req_i ? LOCKED : UNLOCKED;
`endif
      LOCKOUT: if (tmr_q == '0) begin
        fail_d  = '0;
        state_d = LOCKED;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LOCKED;
      cnt_q   <= '0;
      buf_q   <= '0;
      tmr_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      tmr_q   <= tmr_d;
      fail_q  <= fail_d;
    end
  end

  assign state_o      = state_q;
  assign unlocked_o   = state_q == UNLOCKED;
  assign error_o      = state_q == ERROR;
  assign lockout_o    = state_q == LOCKOUT;
  assign tries_left_o = FW'(MAX_TRIES) - fail_q;
endmodule

// File: tb/tb_code_lock_fsm.sv
// tb_code_lock_fsm: table vectors, directed corner sequences and a random run against a behavioural model.
module tb_code_lock_fsm;
  localparam int N  = 4;
  localparam int MT = 3;
  localparam int LC = 16;
  localparam int UC = 8;

  logic        clk = 0;
  logic        rst = 0, dv = 0, lr = 0;
  logic [3:0]  dig = 0;
  logic [15:0] code = 16'h1234;
  logic [2:0]  state;
  logic        unlocked, error, lockout;
  logic [1:0]  tries;

  int tests = 0, fails = 0;

  code_lock_fsm #(.DIGIT_W(4), .NUM_DIGITS(N), .MAX_TRIES(MT),
                  .LOCKOUT_CYCLES(LC), .UNLOCK_CYCLES(UC)) dut (
    .clk_i(clk), .reset_i(rst), .digit_valid_i(dv), .digit_i(dig), .code_i(code),
    .lock_req_i(lr), .state_o(state), .unlocked_o(unlocked), .error_o(error),
    .lockout_o(lockout), .tries_left_o(tries));

  always #5 clk = ~clk;

  // Reference model: digits collected so far, pending verify/error flags and
  // remaining-cycle counts for the timed modes.
  int  m_entry[$];
  bit  m_verify, m_err, m_unl;
  int  m_lo_left, m_unl_left, m_fails;

  task automatic model_reset();
    m_entry.delete();
    m_verify = 0; m_err = 0; m_unl = 0;
    m_lo_left = 0; m_unl_left = 0; m_fails = 0;
  endtask

  function automatic int m_state();
    if (m_lo_left > 0) return 5;
    if (m_unl) return 4;
    if (m_err) return 3;
    if (m_verify) return 2;
    return m_entry.size() > 0 ? 1 : 0;
  endfunction

  task automatic model_step();
    int ok;
    if (rst) begin
      model_reset();
    end else if (m_lo_left > 0) begin
      m_lo_left--;
      if (m_lo_left == 0) m_fails = 0;
    end else if (m_unl) begin
`ifdef CODE_LOCK_AUTO_RELOCK_EN
      m_unl_left--;
      if (lr || m_unl_left == 0) m_unl = 0;
`else
      if (lr) m_unl = 0;
`endif
    end else if (m_err) begin
      m_err = 0;
    end else if (m_verify) begin
      m_verify = 0;
      ok = 1;
      for (int i = 0; i < N; i++)
        if (m_entry[i] != ((code >> (4 * (N - 1 - i))) & 16'hF)) ok = 0;
      m_entry.delete();
      if (ok != 0) begin
        m_unl = 1; m_fails = 0; m_unl_left = UC;
      end else begin
        m_fails++;
        if (m_fails == MT) m_lo_left = LC; else m_err = 1;
      end
    end else if (dv) begin
      m_entry.push_back(int'(dig));
      if (m_entry.size() == N) m_verify = 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [3:0] d, input bit l);
    int es;
    rst = r; dv = v; dig = d; lr = l;
    @(posedge clk);
    model_step();
    #1;
    es = m_state();
    chk("model_state", int'(state), es);
    chk("model_tries", int'(tries), MT - m_fails);
    chk("model_flags", int'({unlocked, error, lockout}), int'({es == 4, es == 3, es == 5}));
  endtask

  task automatic enter(input logic [15:0] v);
    for (int i = 0; i < N; i++) cycle(0, 1, v[15 - 4 * i -: 4], 0);
    cycle(0, 0, 4'h0, 0);
  endtask

  typedef struct {
    bit r; bit v; logic [3:0] d; bit l;
    int st; int tl;
  } vec_t;
  vec_t vt[$];

  initial begin
    int n;
    model_reset();
    // Tests 1-3: reset, good entry, relock, single bad entry.
    vt = '{
      '{1, 0, 4'h0, 0, 0, 3}, '{1, 0, 4'h0, 0, 0, 3},
      '{0, 1, 4'h1, 0, 1, 3}, '{0, 1, 4'h2, 0, 1, 3}, '{0, 1, 4'h3, 0, 1, 3},
      '{0, 1, 4'h4, 0, 2, 3}, '{0, 1, 4'h7, 0, 4, 3}, '{0, 1, 4'h7, 0, 4, 3},
      '{0, 0, 4'h0, 1, 0, 3},
      '{0, 1, 4'h1, 0, 1, 3}, '{0, 1, 4'h2, 0, 1, 3}, '{0, 1, 4'h3, 0, 1, 3},
      '{0, 1, 4'h5, 0, 2, 3}, '{0, 1, 4'h1, 1, 3, 2}, '{0, 0, 4'h0, 1, 0, 2}
    };
    foreach (vt[i]) begin
      cycle(vt[i].r, vt[i].v, vt[i].d, vt[i].l);
      chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
      chk($sformatf("vec%0d_tries", i), int'(tries), vt[i].tl);
      chk($sformatf("vec%0d_flags", i), int'({unlocked, error, lockout}),
          int'({vt[i].st == 4, vt[i].st == 3, vt[i].st == 5}));
    end

    // Test 4: three failures -> LOCKOUT for exactly LC cycles, digits ignored.
    cycle(1, 0, 4'h0, 0);
    enter(16'h9999); cycle(0, 0, 4'h0, 0);
    enter(16'h9999); cycle(0, 0, 4'h0, 0);
    enter(16'h9999);
    chk("lockout_entry", int'(lockout), 1);
    chk("lockout_tries", int'(tries), 0);
    n = 1;
    for (int i = 0; i < 40 && lockout; i++) begin
      cycle(0, 1, 4'($urandom_range(0, 15)), 1);
      if (lockout) n++;
    end
    chk("lockout_len", n, LC);
    chk("after_lockout_state", int'(state), 0);
    chk("after_lockout_tries", int'(tries), 3);
    enter(16'h1234);
    chk("unlock_after_lockout", int'(state), 4);
    cycle(0, 0, 4'h0, 1);

    // Test 5: reset mid-entry discards the partial entry.
    cycle(0, 1, 4'h1, 0); cycle(0, 1, 4'h2, 0);
    cycle(1, 1, 4'h3, 0);
    chk("midreset_state", int'(state), 0);
    enter(16'h1234);
    chk("midreset_unlock", int'(state), 4);

    // Test 6: UNLOCKED residency without lock_req.
    n = 1;
    for (int i = 0; i < 50 && state == 3'b100; i++) begin
      cycle(0, 1, 4'h1, 0);
      if (state == 3'b100) n++;
    end
`ifdef CODE_LOCK_AUTO_RELOCK_EN
    chk("auto_relock_len", n, UC);
    chk("auto_relock_state", int'(state), 0);
`else
    chk("unlocked_hold", n, 51);
    cycle(0, 0, 4'h0, 1);
    chk("relock_state", int'(state), 0);
`endif

    // Random run against the model; digits often follow the code so matches occur.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      int k;
      if (i % 500 == 250) code = 16'($urandom);
      k = m_entry.size() < N ? m_entry.size() : 0;
      d = ($urandom_range(0, 3) != 0) ? 4'((code >> (4 * (N - 1 - k))) & 16'hF)
                                      : 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, d,
            $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
- Parametrised keypad code-lock controller; successor to the fixed 3-bit lock state register.
- Collects NUM_DIGITS digits, compares them against a supplied code and grants or denies access.
- Counts failed attempts and enters a timed LOCKOUT after MAX_TRIES consecutive failures.
- Sits between the keypad debouncer/encoder and the actuator driver; state is exported for waveform inspection.

Parameters:
- DIGIT_W, 4, bits per entered digit.
- NUM_DIGITS, 4, digits per code; must be >= 2.
- MAX_TRIES, 3, consecutive failed verifications before LOCKOUT; must be >= 1.
- LOCKOUT_CYCLES, 16, clock cycles spent in LOCKOUT; must be >= 1.
- UNLOCK_CYCLES, 8, auto-relock timeout in UNLOCKED; used only with CODE_LOCK_AUTO_RELOCK_EN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- digit_valid  in  1  one-cycle strobe; digit is valid this cycle.
- digit  in  DIGIT_W  entered digit value.
- code  in  NUM_DIGITS*DIGIT_W  stored code; first digit sits in the MS DIGIT_W bits; sampled in VERIFY.
- lock_req  in  1  request to relock from UNLOCKED.
- state  out  3  current state encoding.
- unlocked  out  1  high exactly while state==UNLOCKED.
- error  out  1  high exactly while state==ERROR.
- lockout  out  1  high exactly while state==LOCKOUT.
- tries_left  out  $clog2(MAX_TRIES+1)  MAX_TRIES minus consecutive failures.

Behaviour:
- State encoding: LOCKED=000, INPUT=001, VERIFY=010, ERROR=011, UNLOCKED=100, LOCKOUT=101.
  - Codes 110 and 111 are illegal; go to LOCKED on the next edge.
- State is a registered 3-bit value; all outputs decode from registers, with no combinational input-to-output path.
- Reset, in any state including mid-entry, takes effect on the next edge:
  - state=LOCKED, digit counter=0, entry buffer=0, timer=0, fail count=0.
  - tries_left=MAX_TRIES; unlocked/error/lockout=0.
- LOCKED: on digit_valid, store the digit at index 0, set counter=1 and go to INPUT.
- INPUT:
  - On each digit_valid, store the digit at index counter and increment counter.
  - When the digit at index NUM_DIGITS-1 is stored, go to VERIFY.
  - Without digit_valid, hold; there is no idle timeout.
- VERIFY lasts exactly one cycle; digit_valid is ignored. It compares the full entry buffer against code.
  - Match: go to UNLOCKED, clear fail count.
  - Mismatch with fail count+1 < MAX_TRIES: increment fail count, go to ERROR.
  - Mismatch with fail count+1 == MAX_TRIES: increment fail count (tries_left=0), load timer with LOCKOUT_CYCLES-1, go to LOCKOUT.
- ERROR lasts exactly one cycle, then LOCKED; digit_valid is ignored.
- LOCKOUT:
  - digit_valid and lock_req are ignored; the timer decrements every cycle.
  - When timer==0, go to LOCKED and clear fail count.
  - Total residency is exactly LOCKOUT_CYCLES cycles.
- UNLOCKED:
  - digit_valid is ignored.
  - lock_req=1 causes LOCKED on the next edge.
  - lock_req in any other state is ignored.
- Latency: the last digit is accepted at edge k; state=VERIFY after edge k; result state after edge k+1.
- Counter and timer widths are $clog2 of their maxima, minimum 1; no wrap-around is reachable.

Optional Feature:
- Macro: CODE_LOCK_AUTO_RELOCK_EN.
- Defined:
  - Entering UNLOCKED loads the timer with UNLOCK_CYCLES-1; it decrements each cycle.
  - At timer==0, go to LOCKED, so residency is UNLOCK_CYCLES cycles.
  - lock_req still relocks immediately; if both occur on the same cycle, the result is LOCKED.
- Undefined: UNLOCKED holds until lock_req or reset; UNLOCK_CYCLES is unused and no relock timer is built.

Test Plan:
1. Reset asserted for 2 cycles -> state=000, tries_left=3, unlocked=error=lockout=0.
2. code=16'h1234; strobe digits 1,2,3,4 on consecutive cycles -> state=010 for one cycle, then 100 with unlocked=1, tries_left=3; lock_req pulse -> 000.
3. code=16'h1234; enter 1,2,3,5 -> VERIFY, then ERROR (error=1) for exactly one cycle, then LOCKED with tries_left=2.
4. Three wrong entries (9,9,9,9) -> the third goes to LOCKOUT:
   - tries_left=0 and lockout=1 for exactly 16 cycles.
   - Digits strobed during LOCKOUT are ignored.
   - Then LOCKED with tries_left=3; entering 1,2,3,4 unlocks.
5. Enter 1,2, then assert reset one cycle -> LOCKED with counter cleared; then 1,2,3,4 unlocks (the stale partial entry has no effect).
6. With CODE_LOCK_AUTO_RELOCK_EN, unlock with 1,2,3,4 and do not assert lock_req -> state=100 for exactly 8 cycles, then 000; without the macro, state=100 persists for 50 cycles.
